prog_seq: RTL and testbench

Parametrised program sequencer for the core's fetch stage. It owns the program counter, a writable jump-target LUT, and the req/done run handshake with end-of-program detection. It generalises the single-width PC/LUT pair with a configurable width, LUT depth and end address, plus stall, halt and cycle counting. Drives instr_ROM address and tells the top level when the program has finished.

---
 rtl/prog_seq_if.sv | 35 +++
 rtl/prog_seq.sv | 118 +++++++++++
 tb/tb_prog_seq.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_seq_if.sv
// Run/jump/LUT-write handshake bundle between the fetch-stage controller and prog_seq.
// The controller uses the master modport; the sequencer uses the slave modport.
interface prog_seq_if #(
    parameter int unsigned D  = 12,
    parameter int unsigned LW = 5,
    parameter int unsigned CW = 16
) ();
    logic          req;
    logic          stall;
    logic          reljump_en;
    logic          absjump_en;
    logic [LW-1:0] lut_idx;
    logic          halt;
    logic          lut_wr_en;
    logic [LW-1:0] lut_wr_addr;
    logic [D-1:0]  lut_wr_data;
    logic [D-1:0]  prog_ctr;
    logic          fetch_valid;
    logic          busy;
    logic          done;
    logic [CW-1:0] cycle_cnt;
    logic          timeout;

    modport master (
        output req, stall, reljump_en, absjump_en, lut_idx, halt,
               lut_wr_en, lut_wr_addr, lut_wr_data,
        input  prog_ctr, fetch_valid, busy, done, cycle_cnt, timeout
    );

    modport slave (
        input  req, stall, reljump_en, absjump_en, lut_idx, halt,
               lut_wr_en, lut_wr_addr, lut_wr_data,
        output prog_ctr, fetch_valid, busy, done, cycle_cnt, timeout
    );
endinterface

// File: rtl/prog_seq.sv
// Program sequencer: PC, writable jump-target LUT, req/done run handshake, cycle counter.
// Define PROG_SEQ_WATCHDOG_EN to end a run with timeout=1 once cycle_cnt saturates.
module prog_seq #(
    parameter int unsigned D        = 12,
    parameter int unsigned LW       = 5,
    parameter int unsigned END_ADDR = 128,
    parameter int unsigned CW       = 16
) (
    input  logic      clk,
    input  logic      reset,
    prog_seq_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [D-1:0] EndPc = D'(END_ADDR);

    state_e        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [D-1:0]  lut_q [2**LW];
    logic [D-1:0]  lut_val;
    logic          at_end;
    logic          cnt_sat;

    // Combinational read returns the pre-write entry during a same-cycle write.
    assign lut_val = lut_q[bus.lut_idx];
    assign at_end  = (pc_q == EndPc);
    assign cnt_sat = &cnt_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.req) begin
                    state_d = StRun;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (!cnt_sat) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (at_end || bus.halt) begin
                    state_d = StDone;
                end else if (!bus.stall) begin
                    if (bus.absjump_en) begin
                        pc_d = lut_val;
                    end else if (bus.reljump_en) begin
                        pc_d = pc_q + lut_val;
                    end else begin
                        pc_d = pc_q + D'(1);
                    end
                end
`ifdef PROG_SEQ_WATCHDOG_EN
                if (cnt_sat) begin
                    state_d = StDone;
                    pc_d    = pc_q;
                end
`endif
            end
            StDone: begin
                if (!bus.req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lut_q <= '{default: '0};
        end else if (bus.lut_wr_en) begin
            lut_q[bus.lut_wr_addr] <= bus.lut_wr_data;
        end
    end

`ifdef PROG_SEQ_WATCHDOG_EN
    logic timeout_q;

    // Sticky until the next run starts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else if (state_q == StIdle && bus.req) begin
            timeout_q <= 1'b0;
        end else if (state_q == StRun && cnt_sat) begin
            timeout_q <= 1'b1;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.prog_ctr    = pc_q;
    assign bus.cycle_cnt   = cnt_q;
    assign bus.busy        = (state_q == StRun);
    assign bus.done        = (state_q == StDone);
    // The cycle that sits on END_ADDR fetches nothing.
    assign bus.fetch_valid = (state_q == StRun) && !bus.stall && !at_end;
endmodule

// File: tb/tb_prog_seq.sv
// Self-checking bench for prog_seq: vector table, directed multi-cycle sequences,
// watchdog/saturation instance and a randomized run against a behavioural model.
module tb_prog_seq;
    localparam int unsigned D        = 12;
    localparam int unsigned LW       = 5;
    localparam int unsigned CW       = 16;
    localparam int unsigned END_ADDR = 128;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    prog_seq_if #(.D(D), .LW(LW), .CW(CW)) bus ();
    prog_seq #(.D(D), .LW(LW), .END_ADDR(END_ADDR), .CW(CW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Narrow counter, short program: exercises saturation / watchdog.
    prog_seq_if #(.D(D), .LW(LW), .CW(4)) wbus ();
    prog_seq #(.D(D), .LW(LW), .END_ADDR(100), .CW(4)) wdut (
        .clk  (clk),
        .reset(reset),
        .bus  (wbus)
    );

    typedef struct {
        logic        req;
        logic        stall;
        logic        abs_j;
        logic        rel_j;
        logic        halt;
        logic [4:0]  idx;
        logic        wr;
        logic [4:0]  wa;
        logic [11:0] wd;
        logic [11:0] e_pc;
        logic        e_fv;
        logic        e_busy;
        logic        e_done;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV = 21;
    vec_t vec [NV];

    // Behavioural model state
    bit m_run;
    bit m_done;
    int m_pc;
    int m_cnt;
    int m_lut [32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int pc, input int fv, input int busy,
                            input int done, input int cnt);
        chk({tag, ".prog_ctr"}, 32'(bus.prog_ctr), pc);
        chk({tag, ".fetch_valid"}, 32'(bus.fetch_valid), fv);
        chk({tag, ".busy"}, 32'(bus.busy), busy);
        chk({tag, ".done"}, 32'(bus.done), done);
        chk({tag, ".cycle_cnt"}, 32'(bus.cycle_cnt), cnt);
    endtask

    task automatic drive(input logic req, input logic stall, input logic abs_j,
                         input logic rel_j, input logic halt, input logic [4:0] idx,
                         input logic wr, input logic [4:0] wa, input logic [11:0] wd);
        bus.req         = req;
        bus.stall       = stall;
        bus.absjump_en  = abs_j;
        bus.reljump_en  = rel_j;
        bus.halt        = halt;
        bus.lut_idx     = idx;
        bus.lut_wr_en   = wr;
        bus.lut_wr_addr = wa;
        bus.lut_wr_data = wd;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
    endtask

    initial begin
        bit r_req, r_stall, r_abs, r_rel, r_halt, r_wr;
        int r_idx, r_wa, r_wd;

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        wbus.req = 0; wbus.stall = 0; wbus.absjump_en = 0; wbus.reljump_en = 0;
        wbus.halt = 0; wbus.lut_idx = 0; wbus.lut_wr_en = 0; wbus.lut_wr_addr = 0;
        wbus.lut_wr_data = 0;
        tick();
        chk_outs("reset", 0, 0, 0, 0, 0);
        chk("reset.timeout", 32'(bus.timeout), 0);
        tick();
        reset = 1'b1;

        // Inputs for one cycle, and the outputs expected during that cycle.
        //          req s  ab rl h  idx wr wa wd      pc     fv bsy dn cnt
        vec[0]  = '{0, 0, 0, 0, 0, 0, 1, 3, 12'hFFE, 12'h000, 0, 0, 0, 0};
        vec[1]  = '{0, 0, 0, 0, 0, 0, 1, 4, 12'hFFD, 12'h000, 0, 0, 0, 0};
        vec[2]  = '{0, 0, 0, 0, 0, 0, 1, 1, 12'h050, 12'h000, 0, 0, 0, 0};
        vec[3]  = '{1, 1, 1, 0, 0, 1, 0, 0, 12'h000, 12'h000, 0, 0, 0, 0};
        vec[4]  = '{0, 0, 1, 1, 0, 1, 1, 1, 12'h060, 12'h000, 1, 1, 0, 0};
        vec[5]  = '{0, 0, 1, 0, 0, 1, 1, 5, 12'h00A, 12'h050, 1, 1, 0, 1};
        vec[6]  = '{0, 1, 0, 0, 0, 0, 0, 0, 12'h000, 12'h060, 0, 1, 0, 2};
        vec[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h060, 1, 1, 0, 3};
        vec[8]  = '{0, 0, 1, 0, 0, 4, 0, 0, 12'h000, 12'h061, 1, 1, 0, 4};
        vec[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'hFFD, 1, 1, 0, 5};
        vec[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'hFFE, 1, 1, 0, 6};
        vec[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'hFFF, 1, 1, 0, 7};
        vec[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 1, 1, 0, 8};
        vec[13] = '{0, 0, 0, 1, 0, 4, 0, 0, 12'h000, 12'h001, 1, 1, 0, 9};
        vec[14] = '{0, 0, 1, 0, 0, 5, 0, 0, 12'h000, 12'hFFE, 1, 1, 0, 10};
        vec[15] = '{0, 0, 0, 1, 0, 3, 0, 0, 12'h000, 12'h00A, 1, 1, 0, 11};
        vec[16] = '{0, 0, 1, 0, 1, 1, 0, 0, 12'h000, 12'h008, 1, 1, 0, 12};
        vec[17] = '{1, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h008, 0, 0, 1, 13};
        vec[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h008, 0, 0, 1, 13};
        vec[19] = '{1, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h008, 0, 0, 0, 13};
        vec[20] = '{0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 1, 1, 0, 0};

        for (int i = 0; i < NV; i++) begin
            drive(vec[i].req, vec[i].stall, vec[i].abs_j, vec[i].rel_j, vec[i].halt,
                  vec[i].idx, vec[i].wr, vec[i].wa, vec[i].wd);
            #1;
            chk_outs($sformatf("vec%0d", i), int'(vec[i].e_pc), int'(vec[i].e_fv),
                     int'(vec[i].e_busy), int'(vec[i].e_done), int'(vec[i].e_cnt));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Full run to END_ADDR
        do_reset();
        bus.req = 1;
        tick();
        bus.req = 0;
        for (int i = 0; i <= int'(END_ADDR); i++) begin
            if (i % 16 == 0 || i == int'(END_ADDR))
                chk_outs($sformatf("run.pc%0d", i), i, (i != int'(END_ADDR)) ? 1 : 0, 1, 0, i);
            tick();
        end
        chk_outs("run.end", int'(END_ADDR), 0, 0, 1, int'(END_ADDR) + 1);

        // Stall and halt
        tick();
        chk("idle.done", 32'(bus.done), 0);
        bus.req = 1;
        tick();
        bus.req = 0;
        repeat (20) tick();
        chk_outs("stall.pre", 20, 1, 1, 0, 20);
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_outs($sformatf("stall%0d", i), 20, 0, 1, 0, 20 + i);
            tick();
        end
        bus.stall = 0;
        repeat (5) tick();
        chk_outs("halt.pre", 25, 1, 1, 0, 28);
        bus.halt = 1;
        tick();
        bus.halt = 0;
        chk_outs("halt.post", 25, 0, 0, 1, 29);

        // DONE held by req, release, restart, async reset mid-run
        bus.req = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("hold%0d.done", i), 32'(bus.done), 1);
        end
        bus.req = 0;
        tick();
        chk("rel.done", 32'(bus.done), 0);
        chk("rel.busy", 32'(bus.busy), 0);
        bus.req = 1;
        tick();
        bus.req = 0;
        chk_outs("restart", 0, 1, 1, 0, 0);
        repeat (40) tick();
        chk("midrun.pc", 32'(bus.prog_ctr), 40);
        #2;
        reset = 1'b0;
        #1;
        chk_outs("async_rst", 0, 0, 0, 0, 0);
        chk("async_rst.timeout", 32'(bus.timeout), 0);
        #2;
        reset = 1'b1;
        tick();
        bus.req = 1;
        tick();
        bus.req = 0;
        bus.absjump_en = 1;
        bus.lut_idx = 1;
        tick();
        bus.absjump_en = 0;
        chk("lut_cleared.pc", 32'(bus.prog_ctr), 0);

        // Counter saturation / watchdog on the narrow instance
        do_reset();
        wbus.req = 1;
        tick();
        wbus.req = 0;
        for (int i = 0; i < 200 && !wbus.done; i++) tick();
        chk("wd.done", 32'(wbus.done), 1);
        chk("wd.cnt", 32'(wbus.cycle_cnt), 15);
`ifdef PROG_SEQ_WATCHDOG_EN
        chk("wd.pc", 32'(wbus.prog_ctr), 15);
        chk("wd.timeout", 32'(wbus.timeout), 1);
`else
        chk("wd.pc", 32'(wbus.prog_ctr), 100);
        chk("wd.timeout", 32'(wbus.timeout), 0);
`endif
        tick();
        wbus.req = 1;
        tick();
        wbus.req = 0;
        chk("wd.rerun.timeout", 32'(wbus.timeout), 0);
        chk("wd.rerun.pc", 32'(wbus.prog_ctr), 0);

        // Randomized run against the model
        do_reset();
        m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
        for (int i = 0; i < 32; i++) m_lut[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            r_req   = ($urandom_range(0, 99) < 50);
            r_stall = ($urandom_range(0, 99) < 20);
            r_abs   = ($urandom_range(0, 99) < 5);
            r_rel   = ($urandom_range(0, 99) < 10);
            r_halt  = ($urandom_range(0, 99) < 3);
            r_wr    = ($urandom_range(0, 99) < 15);
            r_idx   = int'($urandom_range(0, 31));
            r_wa    = int'($urandom_range(0, 31));
            r_wd    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(120, 128))
                                                  : int'($urandom_range(0, 4095));
            drive(r_req, r_stall, r_abs, r_rel, r_halt, 5'(r_idx), r_wr, 5'(r_wa), 12'(r_wd));
            #1;
            chk_outs($sformatf("rnd%0d", c), m_pc,
                     (m_run && !r_stall && m_pc != int'(END_ADDR)) ? 1 : 0,
                     m_run ? 1 : 0, m_done ? 1 : 0, m_cnt);
            chk($sformatf("rnd%0d.timeout", c), 32'(bus.timeout), 0);
            tick();
            if (m_run) begin
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                if (m_pc == int'(END_ADDR) || r_halt) begin
                    m_run  = 0;
                    m_done = 1;
                end else if (!r_stall) begin
                    if (r_abs) m_pc = m_lut[r_idx];
                    else if (r_rel) m_pc = (m_pc + m_lut[r_idx]) % 4096;
                    else m_pc = (m_pc + 1) % 4096;
                end
            end else if (m_done) begin
                if (!r_req) m_done = 0;
            end else if (r_req) begin
                m_run = 1;
                m_pc  = 0;
                m_cnt = 0;
            end
            if (r_wr) m_lut[r_wa] = r_wd;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
